pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 10-bit core.
- Drives the fetch_op code of the fetch-to-decode register, the PC enable and select, and the decode-to-execute bubble.
- Resolves load-use stalls, jump and compare flushes, memory-busy waits, and HALT.
- Sits beside the F/D register. Inputs come from the decode and execute stages; outputs feed PC logic, F/D and D/X.

Parameters:
LOAD_LAT, 1, stall cycles inserted per load-use hazard (1..3)
R0_ZERO, 1, when 1 a source or destination of r0 never creates a hazard
CNT_W, 16, width of the performance counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
dec_rs1  in  3  decode-stage source reg 1
dec_rs2  in  3  decode-stage source reg 2
dec_use1  in  1  decode instr reads rs1
dec_use2  in  1  decode instr reads rs2
ex_rd  in  3  execute-stage destination reg
ex_is_load  in  1  execute-stage instr is a load
jmp_control  in  1  unconditional jump resolved in decode
comp_taken  in  1  compare/branch resolved taken in execute
halt_dec  in  1  decode holds HALT (opcode 1111)
mem_busy  in  1  data memory not ready
resume  in  1  leave HALT
fetch_op  out  2  00 pass, 01 flush-on-jump, 10 NOP bubble, 11 HALT word
pc_en  out  1  PC update enable
pc_sel  out  2  00 pc+1, 01 jump target, 10 branch target
dx_bubble  out  1  inject NOP into D/X
halted  out  1  core halted
stall_cnt  out  CNT_W  stall cycles (optional feature)
flush_cnt  out  CNT_W  flush events (optional feature)

Behaviour:
- FSM states: RUN, LD_STALL, MEM_WAIT, HALT.
- Outputs are combinational from state and inputs. State and the LD_STALL counter are registered.
- Reset (rst=0, asynchronous) forces:
  - state=RUN, counter=0
  - fetch_op=10, pc_en=0, pc_sel=00, dx_bubble=1, halted=0, counters=0
- First cycle after reset release: normal RUN outputs.
- hazard = ex_is_load & ((dec_use1 & dec_rs1==ex_rd) | (dec_use2 & dec_rs2==ex_rd)). When R0_ZERO=1, the hazard is masked if ex_rd==0.
- RUN priority, highest first:
  1. comp_taken: fetch_op=10, dx_bubble=1, pc_sel=10, pc_en=1, stay RUN. This squashes F/D and D/X.
  2. mem_busy: pc_en=0, fetch_op=00, dx_bubble=0. Next state MEM_WAIT.
  3. hazard: pc_en=0, fetch_op=00 (re-latches the same fetch), dx_bubble=1, counter loads LOAD_LAT-1. Next state LD_STALL, unless LOAD_LAT=1, in which case stay RUN.
  4. jmp_control: fetch_op=01, pc_sel=01, pc_en=1, dx_bubble=0.
  5. halt_dec: fetch_op=11, pc_en=0, dx_bubble=1. Next state HALT.
  6. Otherwise: fetch_op=00, pc_sel=00, pc_en=1, dx_bubble=0.
- LD_STALL:
  - Outputs as in hazard case 3. Counter decrements each cycle.
  - Return to RUN when the counter is 0 at a clock edge.
  - comp_taken pre-empts: apply case 1, go to RUN, clear counter.
- MEM_WAIT:
  - pc_en=0, fetch_op=00, dx_bubble=0.
  - Leave to RUN on the first cycle mem_busy=0; RUN rules apply that same cycle.
  - comp_taken while busy is held pending: it is applied in the exit cycle.
- HALT:
  - fetch_op=11, pc_en=0, dx_bubble=1, halted=1.
  - resume=1 takes effect next cycle: RUN with pc_en=1 and pc_sel=00.
  - All other inputs are ignored in HALT.
- Simultaneous comp_taken and jmp_control: branch wins; the jump is squashed with the flushed decode instruction.
- Reset mid-stall or mid-halt: immediate return to the reset values.

Optional Feature:
HAZARD_PERF_EN
- Defined:
  - stall_cnt increments in every cycle with pc_en=0 outside HALT.
  - flush_cnt increments on every comp_taken or jmp_control flush.
  - Both saturate at all-ones and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared package pipe_pkg holds:
  - fetch_op encodings (FOP_PASS=00, FOP_JFLUSH=01, FOP_NOP=10, FOP_HALT=11)
  - pc_sel encodings
  - NOP_INSTR=10'b0100000000, HALT_INSTR=10'b1111000000
  - FSM state enum
- One sub-module, hazard_detect: purely combinational, produces the hazard signal including the R0_ZERO mask.

Test Plan:
- Reset: assert rst=0 mid-run -> immediately fetch_op=10, pc_en=0, halted=0. Release -> next cycle fetch_op=00, pc_en=1.
- Load-use: ex_is_load=1, ex_rd=3, dec_rs1=3, dec_use1=1 (LOAD_LAT=2) -> 2 cycles of pc_en=0, dx_bubble=1, then RUN. With ex_rd=0 and R0_ZERO=1 -> no stall.
- Jump: jmp_control=1 -> fetch_op=01, pc_sel=01, pc_en=1 for one cycle. Jump with comp_taken=1 in the same cycle -> fetch_op=10, pc_sel=10.
- Memory wait: mem_busy=1 for 3 cycles -> pc_en=0 for 3 cycles. comp_taken pulsed during the wait -> pc_sel=10 in the exit cycle.
- Halt: halt_dec=1 -> fetch_op=11 and halted=1 held for 10 cycles. resume=1 -> next cycle pc_en=1, halted=0.
- HAZARD_PERF_EN: 4 stall cycles plus 2 flushes -> stall_cnt=4, flush_cnt=2. With CNT_W=2, 5 stalls -> stall_cnt=3 (saturated).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the 10-bit core pipeline sequencing controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    FOP_PASS   = 2'b00,
    FOP_JFLUSH = 2'b01,
    FOP_NOP    = 2'b10,
    FOP_HALT   = 2'b11
  } fop_e;

  typedef enum logic [1:0] {
    PCS_INC = 2'b00,
    PCS_JMP = 2'b01,
    PCS_BR  = 2'b10
  } pcsel_e;

  localparam logic [9:0] NOP_INSTR  = 10'b0100000000;
  localparam logic [9:0] HALT_INSTR = 10'b1111000000;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between decode sources and the execute-stage load target.
module hazard_detect #(
  parameter int R0_ZERO = 1
) (
  input  logic [2:0] dec_rs1,
  input  logic [2:0] dec_rs2,
  input  logic       dec_use1,
  input  logic       dec_use2,
  input  logic [2:0] ex_rd,
  input  logic       ex_is_load,
  output logic       hazard
);

  logic raw_hit;
  logic r0_mask;

  assign raw_hit = ex_is_load & ((dec_use1 & (dec_rs1 == ex_rd)) |
                                 (dec_use2 & (dec_rs2 == ex_rd)));
  // r0 is hardwired, so a load into it can never feed a consumer
  assign r0_mask = (R0_ZERO != 0) && (ex_rd == 3'd0);
  assign hazard  = raw_hit & ~r0_mask;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stalls, flushes, memory waits and HALT.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
//
// state       | meaning
// ST_RUN      | normal issue, priority-resolves comp/mem/hazard/jump/halt
// ST_LD_STALL | extra load-use stall cycles, counted down by cnt_q
// ST_MEM_WAIT | data memory busy, comp_taken held pending until exit
// ST_HALT     | core halted until resume
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int R0_ZERO  = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       dec_rs1,
  input  logic [2:0]       dec_rs2,
  input  logic             dec_use1,
  input  logic             dec_use2,
  input  logic [2:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             jmp_control,
  input  logic             comp_taken,
  input  logic             halt_dec,
  input  logic             mem_busy,
  input  logic             resume,
  output logic [1:0]       fetch_op,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             dx_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] LAT_INIT = 2'(LOAD_LAT - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       hazard;
  logic       run_rules;
  logic       comp_eff;
  fop_e       fop_c;
  pcsel_e     sel_c;
  logic       pc_en_c;
  logic       bub_c;
  logic       halted_c;

  hazard_detect #(.R0_ZERO(R0_ZERO)) u_hazard_detect (
    .dec_rs1    (dec_rs1),
    .dec_rs2    (dec_rs2),
    .dec_use1   (dec_use1),
    .dec_use2   (dec_use2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .hazard     (hazard)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    fop_c     = FOP_PASS;
    sel_c     = PCS_INC;
    pc_en_c   = 1'b0;
    bub_c     = 1'b0;
    halted_c  = 1'b0;
    run_rules = 1'b0;
    comp_eff  = comp_taken;

    case (state_q)
      ST_RUN: run_rules = 1'b1;
      ST_LD_STALL: begin
        if (comp_taken) begin
          fop_c   = FOP_NOP;
          sel_c   = PCS_BR;
          pc_en_c = 1'b1;
          bub_c   = 1'b1;
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end else begin
          bub_c = 1'b1;
          if (cnt_q <= 2'd1) begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (mem_busy) begin
          pend_d = pend_q | comp_taken;
        end else begin
          // exit cycle behaves as RUN with any branch seen while busy
          run_rules = 1'b1;
          comp_eff  = comp_taken | pend_q;
          pend_d    = 1'b0;
        end
      end
      ST_HALT: begin
        fop_c    = FOP_HALT;
        bub_c    = 1'b1;
        halted_c = 1'b1;
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (run_rules) begin
      state_d = ST_RUN;
      if (comp_eff) begin
        fop_c   = FOP_NOP;
        sel_c   = PCS_BR;
        pc_en_c = 1'b1;
        bub_c   = 1'b1;
        cnt_d   = 2'd0;
      end else if (mem_busy) begin
        state_d = ST_MEM_WAIT;
      end else if (hazard) begin
        bub_c = 1'b1;
        cnt_d = LAT_INIT;
        if (LOAD_LAT > 1) state_d = ST_LD_STALL;
      end else if (jmp_control) begin
        fop_c   = FOP_JFLUSH;
        sel_c   = PCS_JMP;
        pc_en_c = 1'b1;
      end else if (halt_dec) begin
        fop_c   = FOP_HALT;
        bub_c   = 1'b1;
        state_d = ST_HALT;
      end else begin
        pc_en_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // reset overrides the combinational outputs with a bubble-and-hold pattern
  assign fetch_op  = rst ? fop_c    : FOP_NOP;
  assign pc_sel    = rst ? sel_c    : PCS_INC;
  assign pc_en     = rst & pc_en_c;
  assign dx_bubble = rst ? bub_c    : 1'b1;
  assign halted    = rst & halted_c;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             stall_ev;
  logic             flush_ev;

  assign stall_ev = ~pc_en_c && (state_q != ST_HALT);
  assign flush_ev = (sel_c == PCS_BR) || (fop_c == FOP_JFLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_ev && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (flush_ev && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
